bus_load_receiver: RTL and testbench
====================================

// Module: bus_load_receiver
// PURPOSE
//  Receiving end of the shared 16-bit internal bus that the gate drivers (GatePC, GateMDR, ...) drive.
//  - Samples the bus on a load strobe and holds the value for a downstream consumer.
//  - Uses a valid/ack handshake to pass the value on.
//  - Checks the gate-enable vector at every load and records protocol faults: no driver (floating bus) and multiple drivers (contention).
// PARAMETERS
//  WIDTH      16  bus and data width in bits
//  NUM_GATES  8   number of tristate gate drivers on the bus (one enable each)
//  CNT_WIDTH  8   width of the saturating fault counter
// PORTS
//  clock        in   1          single clock; all state updates on rising edge
//  reset        in   1          synchronous, active-high reset
//  gate_en      in   NUM_GATES  copies of every gate driver's enable (bit i = gate i driving)
//  bus          in   WIDTH      shared tristate bus
//  load         in   1          capture request (LD.x from control)
//  ack          in   1          consumer accepts data_out this cycle
//  clear_err    in   1          clears sticky flags and counter
//  data_out     out  WIDTH      captured bus value
//  valid        out  1          data_out holds an unconsumed capture
//  err_float    out  1          sticky: load seen with zero gates enabled
//  err_contend  out  1          sticky: load seen with >1 gate enabled
//  err_overrun  out  1          sticky: capture overwrote an unconsumed value
//  err_count    out  CNT_WIDTH  saturating count of faulty loads (float or contend)
// BEHAVIOUR
//  - Reset (reset=1 at a rising edge; dominates all inputs): data_out=0, valid=0, all err_*=0, err_count=0, FSM=EMPTY.
//  - Gate count: n = popcount(gate_en), evaluated combinationally in the cycle load=1.
//  - Good load (load=1, n==1): data_out <= bus at the edge; valid=1 in the next cycle (latency 1).
//  - Float load (load=1, n==0):
//      - Bus is undriven, so no capture: data_out and valid are unchanged.
//      - err_float <= 1; err_count += 1.
//  - Contend load (load=1, n>=2):
//      - No capture: data_out and valid are unchanged.
//      - err_contend <= 1; err_count += 1.
//  - err_count saturates at 2^CNT_WIDTH-1 (no wrap).
//  - FSM states: EMPTY (valid=0) and FULL (valid=1).
//    - EMPTY: good load -> FULL. Anything else -> stay EMPTY. ack is ignored.
//    - FULL, ack=1 without good load: consume -> EMPTY.
//    - FULL, good load with ack=1: old value consumed, new value captured -> stay FULL, no overrun.
//    - FULL, good load with ack=0: new value overwrites -> stay FULL, err_overrun <= 1.
//    - FULL, faulty load with ack=1 -> EMPTY. The faulty load still flags its error.
//  - gate_en with load=0 is never checked; multiple or zero drivers between loads are legal.
//  - clear_err=1: err_float, err_contend, err_overrun, err_count <= 0.
//    - If a fault or overrun occurs in the same cycle as clear_err, the new event wins:
//      the flag is set and err_count = 1.
//    - clear_err does not affect data_out, valid or the FSM.
//  - Synthesizable; no x/z inspection of bus. Fault detection relies solely on gate_en.
// TESTING
//  1. Reset: assert reset 2 cycles with load=1, gate_en=8'h01 -> data_out=0, valid=0, all err=0.
//  2. Good load: gate_en=8'h01, bus=16'h3000, load=1 for 1 cycle -> next cycle valid=1, data_out=16'h3000.
//     Then ack=1 -> valid=0 the following cycle.
//  3. Float / contend:
//     - load with gate_en=8'h00 -> err_float=1, err_count=1, valid stays 0.
//     - Then load with gate_en=8'h05 -> err_contend=1, err_count=2, data_out unchanged.
//  4. Overrun vs ack:
//     - FULL with 16'h1111. Load 16'h2222 with ack=0 -> data_out=16'h2222, err_overrun=1.
//     - After clear_err, load 16'h3333 with ack=1 -> data_out=16'h3333, valid=1, err_overrun=0.
//  5. Saturation: 300 float loads with CNT_WIDTH=8 -> err_count=255.
//     clear_err together with a contend load -> err_count=1, err_contend=1, err_float=0.
//  6. Reset mid-operation: FULL with err flags set, reset=1 for 1 cycle -> all outputs 0, FSM EMPTY.
//     Next good load behaves as in scenario 2.

Source files
------------

// File: rtl/bus_load_receiver.sv
// bus_load_receiver: receiving end of the shared internal bus driven by the gate drivers.
// Captures the bus on a load strobe when exactly one gate is driving, then holds the value
// until the consumer acknowledges it. Each load is checked against the gate-enable vector.
// Floating-bus and contention faults are recorded as sticky flags and in a saturating counter.
//
// Ports:
//   clock        in   1          rising-edge clock
//   reset        in   1          synchronous, active-high reset
//   gate_en      in   NUM_GATES  enable copy of every gate driver (bit i = gate i driving)
//   bus          in   WIDTH      shared tristate bus
//   load         in   1          capture request
//   ack          in   1          consumer accepts data_out this cycle
//   clear_err    in   1          clears sticky flags and fault counter
//   data_out     out  WIDTH      captured bus value
//   valid        out  1          data_out holds an unconsumed capture
//   err_float    out  1          sticky: load seen with zero gates enabled
//   err_contend  out  1          sticky: load seen with more than one gate enabled
//   err_overrun  out  1          sticky: capture overwrote an unconsumed value
//   err_count    out  CNT_WIDTH  saturating count of faulty loads
module bus_load_receiver #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_GATES = 8,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] gate_en,
    input  logic [WIDTH-1:0]     bus,
    input  logic                 load,
    input  logic                 ack,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid,
    output logic                 err_float,
    output logic                 err_contend,
    output logic                 err_overrun,
    output logic [CNT_WIDTH-1:0] err_count
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    localparam logic [NUM_GATES-1:0] GateOne = NUM_GATES'(1);
    localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 float_q, float_d;
    logic                 contend_q, contend_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic no_gate, one_gate, multi_gate;
    logic good_load, float_load, contend_load, fault_load, overrun_ev;

    // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
    assign no_gate    = ~|gate_en;
    assign one_gate   = ~no_gate & ~|(gate_en & (gate_en - GateOne));
    assign multi_gate = ~no_gate & ~one_gate;

    assign good_load    = load & one_gate;
    assign float_load   = load & no_gate;
    assign contend_load = load & multi_gate;
    assign fault_load   = float_load | contend_load;
    assign overrun_ev   = (state_q == StFull) & good_load & ~ack;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (good_load) state_d = StFull;
            end
            StFull: begin
                // A good load refills the slot whether or not the old value was consumed.
                if (!good_load && ack) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        data_d = good_load ? bus : data_q;

        // A new event in the same cycle as clear_err takes priority over the clear.
        float_d   = float_load   | (float_q   & ~clear_err);
        contend_d = contend_load | (contend_q & ~clear_err);
        overrun_d = overrun_ev   | (overrun_q & ~clear_err);

        count_d = count_q;
        if (clear_err) begin
            count_d = fault_load ? CNT_WIDTH'(1) : '0;
        end else if (fault_load && count_q != CntMax) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StEmpty;
            data_q    <= '0;
            float_q   <= 1'b0;
            contend_q <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            float_q   <= float_d;
            contend_q <= contend_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign data_out    = data_q;
    assign valid       = (state_q == StFull);
    assign err_float   = float_q;
    assign err_contend = contend_q;
    assign err_overrun = overrun_q;
    assign err_count   = count_q;

endmodule

// File: tb/tb_bus_load_receiver.sv
// Directed testbench for bus_load_receiver: one task per scenario, inline comparisons.
module tb_bus_load_receiver;

    logic        clock;
    logic        reset;
    logic [7:0]  gate_en;
    logic [15:0] bus;
    logic        load;
    logic        ack;
    logic        clear_err;
    logic [15:0] data_out;
    logic        valid;
    logic        err_float;
    logic        err_contend;
    logic        err_overrun;
    logic [7:0]  err_count;

    int vectors;
    int miscompares;

    bus_load_receiver #(
        .WIDTH    (16),
        .NUM_GATES(8),
        .CNT_WIDTH(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .gate_en    (gate_en),
        .bus        (bus),
        .load       (load),
        .ack        (ack),
        .clear_err  (clear_err),
        .data_out   (data_out),
        .valid      (valid),
        .err_float  (err_float),
        .err_contend(err_contend),
        .err_overrun(err_overrun),
        .err_count  (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        load      = 1'b0;
        ack       = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; gate_en = 8'h01; bus = 16'hABCD; ack = 1'b0; clear_err = 1'b0;
        tick();
        tick();
        vectors++;
        if (data_out !== 16'h0000) begin miscompares++;
            $display("FAIL reset_data: got %h expected 0000", data_out); end
        vectors++;
        if ({valid, err_float, err_contend, err_overrun} !== 4'b0000) begin miscompares++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {valid, err_float, err_contend, err_overrun}); end
        vectors++;
        if (err_count !== 8'd0) begin miscompares++;
            $display("FAIL reset_count: got %0d expected 0", err_count); end
        idle();
    endtask

    task automatic test_good_load(input logic [15:0] value);
        gate_en = 8'h01; bus = value; load = 1'b1;
        tick();
        load = 1'b0; bus = 16'hDEAD;
        vectors++;
        if (valid !== 1'b1 || data_out !== value) begin miscompares++;
            $display("FAIL good_load: got valid=%b data=%h expected valid=1 data=%h",
                     valid, data_out, value); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++;
        if (valid !== 1'b0 || data_out !== value) begin miscompares++;
            $display("FAIL good_ack: got valid=%b data=%h expected valid=0 data=%h",
                     valid, data_out, value); end
    endtask

    task automatic test_fault();
        gate_en = 8'h00; bus = 16'h5A5A; load = 1'b1;
        tick();
        vectors++;
        if (err_float !== 1'b1 || err_count !== 8'd1 || valid !== 1'b0) begin miscompares++;
            $display("FAIL float_load: got float=%b count=%0d valid=%b expected 1 1 0",
                     err_float, err_count, valid); end
        gate_en = 8'h05; bus = 16'hFFFF;
        tick();
        load = 1'b0;
        vectors++;
        if (err_contend !== 1'b1 || err_count !== 8'd2 || data_out !== 16'h3000) begin
            miscompares++;
            $display("FAIL contend_load: got contend=%b count=%0d data=%h expected 1 2 3000",
                     err_contend, err_count, data_out); end
        // Many drivers with no load is legal and must not be flagged.
        gate_en = 8'hFF;
        tick();
        gate_en = 8'h00;
        tick();
        vectors++;
        if (err_count !== 8'd2 || valid !== 1'b0) begin miscompares++;
            $display("FAIL no_load_gates: got count=%0d valid=%b expected 2 0",
                     err_count, valid); end
        // ack while EMPTY is ignored.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++;
        if (valid !== 1'b0 || data_out !== 16'h3000) begin miscompares++;
            $display("FAIL empty_ack: got valid=%b data=%h expected 0 3000", valid, data_out); end
    endtask

    task automatic test_overrun();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        vectors++;
        if ({err_float, err_contend, err_count} !== 10'd0 || data_out !== 16'h3000) begin
            miscompares++;
            $display("FAIL clear_err: got float=%b contend=%b count=%0d data=%h expected 0 0 0 3000",
                     err_float, err_contend, err_count, data_out); end
        gate_en = 8'h02; bus = 16'h1111; load = 1'b1;
        tick();
        bus = 16'h2222;
        tick();
        load = 1'b0;
        vectors++;
        if (data_out !== 16'h2222 || err_overrun !== 1'b1 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun: got data=%h ovr=%b valid=%b expected 2222 1 1",
                     data_out, err_overrun, valid); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        vectors++;
        if (err_overrun !== 1'b0 || valid !== 1'b1) begin miscompares++;
            $display("FAIL clear_keeps_valid: got ovr=%b valid=%b expected 0 1",
                     err_overrun, valid); end
        bus = 16'h3333; load = 1'b1; ack = 1'b1;
        tick();
        vectors++;
        if (data_out !== 16'h3333 || valid !== 1'b1 || err_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL load_with_ack: got data=%h valid=%b ovr=%b expected 3333 1 0",
                     data_out, valid, err_overrun); end
        // Overrun coinciding with clear_err: the new event wins.
        bus = 16'h4444; ack = 1'b0; clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        vectors++;
        if (err_overrun !== 1'b1 || data_out !== 16'h4444) begin miscompares++;
            $display("FAIL overrun_vs_clear: got ovr=%b data=%h expected 1 4444",
                     err_overrun, data_out); end
        // Faulty load with ack while FULL consumes the value and still flags.
        gate_en = 8'h00; bus = 16'h7777; ack = 1'b1;
        tick();
        load = 1'b0; ack = 1'b0;
        vectors++;
        if (valid !== 1'b0 || err_float !== 1'b1 || data_out !== 16'h4444 || err_count !== 8'd1)
        begin miscompares++;
            $display("FAIL fault_with_ack: got valid=%b float=%b data=%h count=%0d expected 0 1 4444 1",
                     valid, err_float, data_out, err_count); end
    endtask

    task automatic test_saturation();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        gate_en = 8'h00; load = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        load = 1'b0;
        vectors++;
        if (err_count !== 8'd255 || err_float !== 1'b1) begin miscompares++;
            $display("FAIL saturate: got count=%0d float=%b expected 255 1", err_count, err_float); end
        gate_en = 8'hFF; load = 1'b1; clear_err = 1'b1;
        tick();
        idle();
        vectors++;
        if (err_count !== 8'd1 || err_contend !== 1'b1 || err_float !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_vs_contend: got count=%0d contend=%b float=%b expected 1 1 0",
                     err_count, err_contend, err_float); end
    endtask

    task automatic test_reset_mid();
        gate_en = 8'h10; bus = 16'h5555; load = 1'b1;
        tick();
        bus = 16'h6666;
        tick();
        gate_en = 8'h00;
        tick();
        load = 1'b0;
        vectors++;
        if (valid !== 1'b1 || err_overrun !== 1'b1 || err_float !== 1'b1 || err_count !== 8'd2)
        begin miscompares++;
            $display("FAIL pre_reset: got valid=%b ovr=%b float=%b count=%0d expected 1 1 1 2",
                     valid, err_overrun, err_float, err_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({valid, err_float, err_contend, err_overrun} !== 4'b0000 || data_out !== 16'h0000
            || err_count !== 8'd0) begin miscompares++;
            $display("FAIL mid_reset: got flags=%b data=%h count=%0d expected 0000 0000 0",
                     {valid, err_float, err_contend, err_overrun}, data_out, err_count); end
        test_good_load(16'h3000);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        gate_en = 8'h00; bus = 16'h0000;
        idle();
        test_reset();
        test_good_load(16'h3000);
        test_fault();
        test_overrun();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
